// File: rtl/din_filter_pkg.sv
// rtl/din_filter_pkg.sv - default constants and configuration legality check for din_filter
package din_filter_pkg;

   localparam int N_CH_DEF        = 9;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int DEB_W_DEF       = 4;
   localparam int DEB_CNT_DEF     = 8;

   // DEB_CNT must be reachable by a DEB_W-bit counter without wrapping
   function automatic bit deb_cfg_ok(input int n_ch, input int sync_stages,
                                     input int deb_w, input int deb_cnt);
      return (n_ch >= 1) && (n_ch <= 32) &&
             (sync_stages >= 2) && (sync_stages <= 3) &&
             (deb_w >= 1) && (deb_w <= 30) &&
             (deb_cnt >= 1) && (deb_cnt <= (1 << deb_w) - 1);
   endfunction

endpackage

// File: rtl/din_filter_ch.sv
// rtl/din_filter_ch.sv - one channel: synchroniser, debounce counter, output flop, sticky change flag
module din_filter_ch
   import din_filter_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DEB_W       = DEB_W_DEF,
   parameter int DEB_CNT     = DEB_CNT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   input  logic clr,
   input  logic bypass,
   output logic dout,
   output logic flag,
   output logic flag_nxt
);

   localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_ff;
   logic [DEB_W-1:0]       cnt;
   logic                   dout_d;
   logic                   sync;

   assign sync = sync_ff[SYNC_STAGES-1];

   // Set wins over clear: a toggle seen this cycle always lands in the flag
   assign flag_nxt = (dout ^ dout_d) | (flag & ~clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
         cnt     <= '0;
         dout    <= 1'b0;
         dout_d  <= 1'b0;
         flag    <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
         dout_d  <= dout;
         flag    <= flag_nxt;
         if (bypass) begin
            dout <= sync;
            cnt  <= '0;
         end else if (sync == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            dout <= sync;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/din_filter.sv
// rtl/din_filter.sv - connector input conditioner; optional BYPASS port under DIN_FILTER_BYPASS_EN
module din_filter
   import din_filter_pkg::*;
#(
   parameter int N_CH        = N_CH_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DEB_W       = DEB_W_DEF,
   parameter int DEB_CNT     = DEB_CNT_DEF
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [N_CH-1:0] IO_IN,
   output logic [N_CH-1:0] IO_OUT,
   input  logic [N_CH-1:0] GRP_MASK,
   output logic            GRP_OUT,
   input  logic [N_CH-1:0] CHG_CLR,
   output logic [N_CH-1:0] CHG_FLAG,
   output logic            IRQ
`ifdef DIN_FILTER_BYPASS_EN
   ,
   input  logic            BYPASS
`endif
);

   logic [N_CH-1:0] flag_nxt;
   logic            bypass;

`ifdef DIN_FILTER_BYPASS_EN
   assign bypass = BYPASS;
`else
   assign bypass = 1'b0;
`endif

   if (!deb_cfg_ok(N_CH, SYNC_STAGES, DEB_W, DEB_CNT)) begin : g_bad_cfg
      $error("din_filter: illegal parameter set");
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      din_filter_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_W       (DEB_W),
         .DEB_CNT     (DEB_CNT)
      ) u_ch (
         .clk      (CLK),
         .rst_n    (RST_N),
         .din      (IO_IN[i]),
         .clr      (CHG_CLR[i]),
         .bypass   (bypass),
         .dout     (IO_OUT[i]),
         .flag     (CHG_FLAG[i]),
         .flag_nxt (flag_nxt[i])
      );
   end

   // An empty mask would make the AND vacuously true, so it forces 0 instead
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         GRP_OUT <= 1'b0;
         IRQ     <= 1'b0;
      end else begin
         GRP_OUT <= (GRP_MASK != '0) ? &(IO_OUT | ~GRP_MASK) : 1'b0;
         IRQ     <= |flag_nxt;
      end
   end

endmodule

// File: tb/tb_din_filter.sv
// tb/tb_din_filter.sv - directed, table-driven self-checking bench for din_filter
module tb_din_filter;

   localparam int N = 9;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] io_in;
   logic [N-1:0] io_out;
   logic [N-1:0] grp_mask;
   logic         grp_out;
   logic [N-1:0] chg_clr;
   logic [N-1:0] chg_flag;
   logic         irq;
`ifdef DIN_FILTER_BYPASS_EN
   logic         bypass;
`endif

   int errors = 0;
   int checks = 0;

   din_filter dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .IO_IN    (io_in),
      .IO_OUT   (io_out),
      .GRP_MASK (grp_mask),
      .GRP_OUT  (grp_out),
      .CHG_CLR  (chg_clr),
      .CHG_FLAG (chg_flag),
      .IRQ      (irq)
`ifdef DIN_FILTER_BYPASS_EN
      ,
      .BYPASS   (bypass)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] in_v;
      logic [N-1:0] mask_v;
      logic [N-1:0] exp_out;
      logic         exp_grp;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_flags();
      chg_clr = '1;
      step(1);
      chg_clr = '0;
   endtask

   initial begin
      logic seen_high;

      vecs[0] = '{9'h1C0, 9'h1C0, 9'h1C0, 1'b1};
      vecs[1] = '{9'h140, 9'h1C0, 9'h140, 1'b0};
      vecs[2] = '{9'h1C0, 9'h000, 9'h1C0, 1'b0};
      vecs[3] = '{9'h1FF, 9'h1FF, 9'h1FF, 1'b1};
      vecs[4] = '{9'h1FE, 9'h001, 9'h1FE, 1'b0};
      vecs[5] = '{9'h1FE, 9'h1FE, 9'h1FE, 1'b1};
      vecs[6] = '{9'h000, 9'h100, 9'h000, 1'b0};

      rst_n    = 1'b0;
      io_in    = 9'h1FF;
      grp_mask = '0;
      chg_clr  = '0;
`ifdef DIN_FILTER_BYPASS_EN
      bypass   = 1'b0;
`endif

      // Reset / idle
      step(3);
      check("rst_io_out", 32'(io_out), 32'h0);
      check("rst_chg_flag", 32'(chg_flag), 32'h0);
      check("rst_grp_out", 32'(grp_out), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      rst_n = 1'b1;
      step(9);
      check("boot_io_out_c9", 32'(io_out), 32'h0);
      step(1);
      check("boot_io_out_c10", 32'(io_out), 32'h1FF);
      check("boot_flag_c10", 32'(chg_flag), 32'h0);
      step(1);
      check("boot_flag_c11", 32'(chg_flag), 32'h1FF);
      check("boot_irq_c11", 32'(irq), 32'h1);
      check("boot_grp_mask0", 32'(grp_out), 32'h0);
      clear_flags();
      check("clr_flag", 32'(chg_flag), 32'h0);
      check("clr_irq", 32'(irq), 32'h0);
      io_in = '0;
      step(12);
      check("idle_low", 32'(io_out), 32'h0);
      clear_flags();

      // Glitch reject: 7 cycles high
      io_in[3] = 1'b1;
      step(7);
      io_in[3] = 1'b0;
      step(15);
      check("glitch7_out", 32'(io_out[3]), 32'h0);
      check("glitch7_flag", 32'(chg_flag[3]), 32'h0);
      // 8-cycle pulse passes at cycle 10
      io_in[3] = 1'b1;
      step(8);
      io_in[3] = 1'b0;
      step(1);
      check("pulse8_c9", 32'(io_out[3]), 32'h0);
      step(1);
      check("pulse8_c10", 32'(io_out[3]), 32'h1);
      step(12);
      check("pulse8_fall", 32'(io_out[3]), 32'h0);
      clear_flags();

      // Bounce on ch0: toggle every 3 cycles for 30 cycles
      seen_high = 1'b0;
      for (int k = 0; k < 10; k++) begin
         io_in[0] = ((k % 2) == 0);
         for (int c = 0; c < 3; c++) begin
            step(1);
            seen_high = seen_high | io_out[0];
         end
      end
      io_in[0] = 1'b1;
      for (int c = 0; c < 9; c++) begin
         step(1);
         seen_high = seen_high | io_out[0];
      end
      check("bounce_no_toggle", 32'(seen_high), 32'h0);
      step(1);
      check("bounce_rise_c10", 32'(io_out[0]), 32'h1);
      clear_flags();

      // Group AND table
      for (int v = 0; v < 7; v++) begin
         io_in    = vecs[v].in_v;
         grp_mask = vecs[v].mask_v;
         step(12);
         check($sformatf("grp_vec%0d_out", v), 32'(io_out), 32'(vecs[v].exp_out));
         check($sformatf("grp_vec%0d_grp", v), 32'(grp_out), 32'(vecs[v].exp_grp));
      end
      // Drop ch7: GRP_OUT falls 11 cycles later
      io_in    = 9'h1C0;
      grp_mask = 9'h1C0;
      step(12);
      check("grp_drop_pre", 32'(grp_out), 32'h1);
      io_in = 9'h140;
      step(10);
      check("grp_drop_c10", 32'(grp_out), 32'h1);
      step(1);
      check("grp_drop_c11", 32'(grp_out), 32'h0);
      grp_mask = '0;
      io_in    = '0;
      step(12);
      clear_flags();
      check("pre_race_flag", 32'(chg_flag), 32'h0);

      // Flag race: clear coincides with set
      io_in[2] = 1'b1;
      step(10);
      check("race_out_c10", 32'(io_out[2]), 32'h1);
      chg_clr[2] = 1'b1;
      step(1);
      chg_clr[2] = 1'b0;
      check("race_set_wins", 32'(chg_flag[2]), 32'h1);
      check("race_irq", 32'(irq), 32'h1);
      clear_flags();
      check("race_cleared", 32'(chg_flag[2]), 32'h0);
      check("race_irq_clr", 32'(irq), 32'h0);

      // Reset mid-debounce on ch1
      io_in[1] = 1'b1;
      step(7);
      rst_n = 1'b0;
      #1;
      check("midrst_io_out", 32'(io_out), 32'h0);
      check("midrst_flag", 32'(chg_flag), 32'h0);
      check("midrst_irq", 32'(irq), 32'h0);
      step(2);
      rst_n = 1'b1;
      step(9);
      check("midrst_c9", 32'(io_out), 32'h0);
      step(1);
      check("midrst_c10", 32'(io_out), 32'h006);
      step(2);
      clear_flags();

`ifdef DIN_FILTER_BYPASS_EN
      // Bypass: 1-cycle pulse on ch4 appears SYNC_STAGES+1 cycles later
      bypass   = 1'b1;
      io_in[4] = 1'b1;
      step(1);
      io_in[4] = 1'b0;
      check("byp_c1", 32'(io_out[4]), 32'h0);
      step(1);
      check("byp_c2", 32'(io_out[4]), 32'h0);
      step(1);
      check("byp_c3", 32'(io_out[4]), 32'h1);
      step(1);
      check("byp_c4", 32'(io_out[4]), 32'h0);
      check("byp_flag", 32'(chg_flag[4]), 32'h1);
      bypass = 1'b0;
      step(12);
      check("byp_resume", 32'(io_out), 32'h006);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
